// File: rtl/ff_skid.sv
// Elastic pipeline register: valid/ready on both sides, 2-entry skid buffer, synchronous flush.
// Optional stall counter output enabled by defining BRISC_PIPE_PERF_EN.
module ff_skid #(
    parameter int                 WIDTH       = 32,  // brisc_pkg::REG_LEN
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef BRISC_PIPE_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);

    // Handshake: a transfer happens on a side exactly when valid and ready are both high at posedge clk.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    // in_ready depends only on registered state and flush, never on out_ready.
    assign in_ready  = (state_q != FULL) & ~flush;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    case ({in_fire, out_fire})
                        2'b11: main_d = in_data;
                        2'b10: begin
                            state_d = FULL;
                            skid_d  = in_data;
                        end
                        2'b01: state_d = EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

`ifdef BRISC_PIPE_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of cycles where the head is held back by downstream; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= 32'd0;
        end else if (out_valid & ~out_ready & ~flush & ~(&perf_q)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule
